// File: rtl/dcache_controller_if.sv
// Bundle of the CPU, cache-SRAM and data-memory signals seen by the data-cache controller.
// The controller takes the master modport; the pipeline, SRAM and memory side takes the slave modport.
interface dcache_controller_if #(
  parameter int MEM_ADDR_W = 32,
  parameter int LINE_W     = 256
);
  localparam int TAG_W      = MEM_ADDR_W - 4 - $clog2(LINE_W / 8);
  localparam int SRAM_TAG_W = TAG_W + 2;

  // Pipeline MEM stage
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [MEM_ADDR_W-1:0] cpu_addr_i;
  logic [31:0]           cpu_data_i;
  logic [31:0]           cpu_data_o;
  logic                  cpu_stall_o;

  // Cache SRAM port
  logic [3:0]            sram_idx_o;
  logic [SRAM_TAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic                  sram_en_o;
  logic                  sram_we_o;
  logic [SRAM_TAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  // Data memory req/ack port
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_idx_o, sram_tag_o, sram_data_o, sram_en_o, sram_we_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_addr_o, mem_data_o, mem_en_o, mem_we_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_idx_o, sram_tag_o, sram_data_o, sram_en_o, sram_we_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_addr_o, mem_data_o, mem_en_o, mem_we_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_controller.sv
// Miss-sequencing controller for the 16-set, 2-way, 256-bit-line data cache SRAM.
// Serves word loads/stores on a hit; on a miss writes back a dirty victim, refills, then fills the SRAM.
module dcache_controller #(
  parameter int MEM_ADDR_W = 32,
  parameter int LINE_W     = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.master bus
);
  localparam int OFFSET_W   = $clog2(LINE_W / 8);
  localparam int WORD_SEL_W = $clog2(LINE_W / 32);
  localparam int INDEX_W    = 4;
  localparam int TAG_W      = MEM_ADDR_W - INDEX_W - OFFSET_W;
  localparam int VALID_BIT  = TAG_W + 1;
  localparam int DIRTY_BIT  = TAG_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_FILL
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TAG_W-1:0]    r_victim_tag;
  logic [LINE_W-1:0]   r_victim_line;
  logic [TAG_W-1:0]    r_req_tag;
  logic [INDEX_W-1:0]  r_req_idx;
  logic [LINE_W-1:0]   r_refill_line;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [WORD_SEL_W-1:0] w_word;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_victim_dirty;
  logic [LINE_W-1:0]     w_merged;
  logic                  w_unused_ok;

  assign w_tag          = bus.cpu_addr_i[MEM_ADDR_W-1 -: TAG_W];
  assign w_idx          = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign w_word         = bus.cpu_addr_i[2 +: WORD_SEL_W];
  assign w_hit          = bus.sram_hit_i & bus.sram_tag_i[VALID_BIT];
  assign w_miss         = bus.cpu_req_i & ~w_hit;
  assign w_victim_dirty = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];
  // Accesses are word-granular, so the byte-within-word bits are intentionally ignored.
  assign w_unused_ok    = &{1'b0, bus.cpu_addr_i[1:0]};

  always_comb begin
    w_merged = bus.sram_data_i;
    w_merged[int'(w_word) * 32 +: 32] = bus.cpu_data_i;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first so no path through the case infers a latch.
    w_state_nxt      = r_state;
    bus.cpu_data_o   = '0;
    bus.cpu_stall_o  = 1'b0;
    bus.sram_idx_o   = w_idx;
    bus.sram_tag_o   = '0;
    bus.sram_data_o  = '0;
    bus.sram_en_o    = 1'b1;
    bus.sram_we_o    = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    bus.mem_en_o     = 1'b0;
    bus.mem_we_o     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        bus.sram_en_o = bus.cpu_req_i;
        if (bus.cpu_req_i && w_hit) begin
          if (bus.cpu_we_i) begin
            bus.sram_we_o   = 1'b1;
            bus.sram_tag_o  = {2'b11, w_tag};
            bus.sram_data_o = w_merged;
          end else begin
            bus.cpu_data_o = bus.sram_data_i[int'(w_word) * 32 +: 32];
          end
        end else if (w_miss) begin
          bus.cpu_stall_o = 1'b1;
          w_state_nxt     = w_victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end

      S_WRITEBACK: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {r_victim_tag, r_req_idx, {OFFSET_W{1'b0}}};
        bus.mem_data_o  = r_victim_line;
        if (bus.mem_ack_i) w_state_nxt = S_REFILL;
      end

      S_REFILL: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_en_o    = 1'b1;
        bus.mem_addr_o  = {r_req_tag, r_req_idx, {OFFSET_W{1'b0}}};
        if (bus.mem_ack_i) w_state_nxt = S_FILL;
      end

      S_FILL: begin
        // The SRAM places this line in its LRU way; the next IDLE cycle then sees a hit.
        bus.cpu_stall_o = 1'b1;
        bus.sram_we_o   = 1'b1;
        bus.sram_tag_o  = {2'b10, r_req_tag};
        bus.sram_data_o = r_refill_line;
        w_state_nxt     = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Reset must silence the SRAM and memory ports at once, not at the next edge.
    if (rst_i) begin
      w_state_nxt      = S_IDLE;
      bus.cpu_data_o   = '0;
      bus.cpu_stall_o  = 1'b0;
      bus.sram_idx_o   = '0;
      bus.sram_tag_o   = '0;
      bus.sram_data_o  = '0;
      bus.sram_en_o    = 1'b0;
      bus.sram_we_o    = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      bus.mem_en_o     = 1'b0;
      bus.mem_we_o     = 1'b0;
    end
  end

  // NOTE: state and capture registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_victim_tag  <= '0;
      r_victim_line <= '0;
      r_req_tag     <= '0;
      r_req_idx     <= '0;
      r_refill_line <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_miss) begin
        r_victim_tag  <= bus.sram_tag_i[TAG_W-1:0];
        r_victim_line <= bus.sram_data_i;
        r_req_tag     <= w_tag;
        r_req_idx     <= w_idx;
      end
      if (r_state == S_REFILL && bus.mem_ack_i) begin
        r_refill_line <= bus.mem_data_i;
      end
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural 2-way SRAM and a req/ack data memory.
// Covers reset, cold clean miss, store hit, clean and dirty victim misses, zero-latency ack and reset abort.
module tb_dcache_controller;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural 2-way SRAM: hit way on match, else the LRU way is presented as the victim.
  logic [24:0]  s_tag  [16][2] = '{default: '0};
  logic [255:0] s_data [16][2] = '{default: '0};
  logic         s_lru  [16]    = '{default: 1'b0};
  logic         m_h0, m_h1, m_way;
  int           sram_writes = 0;

  always_comb begin
    m_h0 = s_tag[bus.sram_idx_o][0][24] && (s_tag[bus.sram_idx_o][0][22:0] == bus.cpu_addr_i[31:9]);
    m_h1 = s_tag[bus.sram_idx_o][1][24] && (s_tag[bus.sram_idx_o][1][22:0] == bus.cpu_addr_i[31:9]);
    m_way = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : s_lru[bus.sram_idx_o]);
    bus.sram_hit_i  = m_h0 | m_h1;
    bus.sram_tag_i  = s_tag[bus.sram_idx_o][m_way];
    bus.sram_data_i = s_data[bus.sram_idx_o][m_way];
  end

  always @(posedge clk_i) begin
    if (bus.sram_en_o && bus.sram_we_o) begin
      s_tag[bus.sram_idx_o][m_way]  <= bus.sram_tag_o;
      s_data[bus.sram_idx_o][m_way] <= bus.sram_data_o;
      sram_writes <= sram_writes + 1;
    end
    if (bus.sram_en_o && (bus.sram_hit_i || bus.sram_we_o))
      s_lru[bus.sram_idx_o] <= ~m_way;
  end

  // Data memory: acks after ack_latency waiting cycles; logs every completed transfer.
  int           ack_latency = 0;
  logic         force_ack = 1'b0;
  logic         op_we   [$];
  logic [31:0]  op_addr [$];
  logic [255:0] op_data [$];

  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 16'(k)};
    return l;
  endfunction

  initial begin
    logic [255:0] mem_model [logic [31:0]];
    int mem_wait;
    mem_wait = 0;
    mem_model[32'h40] = {32'h0040_0007, 32'h0040_0006, 32'h0040_0005, 32'h0040_0004,
                         32'h0040_0003, 32'hDEAD_BEEF, 32'h0040_0001, 32'h0040_0000};
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      bus.mem_ack_i = 1'b0;
      if (force_ack) begin
        bus.mem_ack_i = 1'b1;
      end else if (bus.mem_en_o) begin
        if (mem_wait >= ack_latency) begin
          bus.mem_ack_i = 1'b1;
          mem_wait = 0;
          op_we.push_back(bus.mem_we_o);
          op_addr.push_back(bus.mem_addr_o);
          op_data.push_back(bus.mem_data_o);
          if (bus.mem_we_o) mem_model[bus.mem_addr_o] = bus.mem_data_o;
          else bus.mem_data_i = mem_model.exists(bus.mem_addr_o) ? mem_model[bus.mem_addr_o]
                                                                 : pattern_line(bus.mem_addr_o);
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  // Results of the last access.
  int           g_stalls;
  int           we_cycles;
  int           op_base;
  logic [31:0]  g_rdata;
  logic         g_we;
  logic [24:0]  g_tag;
  logic [255:0] g_line;
  logic [24:0]  fill_tag;

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int lat);
    ack_latency    = lat;
    op_base        = op_addr.size();
    g_stalls       = 0;
    we_cycles      = 0;
    fill_tag       = '0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wdata;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!bus.cpu_stall_o) break;
      g_stalls++;
      if (bus.mem_we_o) we_cycles++;
      if (bus.sram_we_o) fill_tag = bus.sram_tag_o;
    end
    g_rdata = bus.cpu_data_o;
    g_we    = bus.sram_we_o;
    g_tag   = bus.sram_tag_o;
    g_line  = bus.sram_data_o;
    @(posedge clk_i);
    #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
  endtask

  logic [255:0] dirty_line;
  int           wr_before;

  initial begin
    dirty_line = {32'h0040_0007, 32'h0040_0006, 32'h0040_0005, 32'h0040_0004,
                  32'h0040_0003, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0040_0000};
    rst_i          = 1'b1;
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_stall",   bus.cpu_stall_o, 0);
    check("rst_sram_en", bus.sram_en_o, 0);
    check("rst_sram_we", bus.sram_we_o, 0);
    check("rst_mem_en",  bus.mem_en_o, 0);
    check("rst_mem_we",  bus.mem_we_o, 0);
    check("rst_data",    bus.cpu_data_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Cold clean miss, ack after 10 waiting cycles.
    do_access(32'h40, 1'b0, '0, 10);
    check("cold_stall_cycles", g_stalls, 13);
    check("cold_ops",          op_addr.size() - op_base, 1);
    check("cold_refill_addr",  op_addr[op_base], 32'h40);
    check("cold_refill_we",    op_we[op_base], 0);
    check("cold_fill_tag",     fill_tag, 25'h100_0000);
    check("cold_load_w0",      g_rdata, 32'h0040_0000);

    do_access(32'h48, 1'b0, '0, 0);
    check("hit_load_stall", g_stalls, 0);
    check("hit_load_w2",    g_rdata, 32'hDEAD_BEEF);

    // Store hit merges word 1 and marks the line dirty.
    do_access(32'h44, 1'b1, 32'h1234_5678, 0);
    check("store_stall", g_stalls, 0);
    check("store_we",    g_we, 1);
    check("store_tag",   g_tag, 25'h180_0000);
    check("store_line",  g_line, dirty_line);
    do_access(32'h44, 1'b0, '0, 0);
    check("store_readback", g_rdata, 32'h1234_5678);

    // Second way of set 2 is invalid: clean victim, no write-back.
    do_access(32'h240, 1'b0, '0, 2);
    check("clean_stall_cycles", g_stalls, 5);
    check("clean_we_cycles",    we_cycles, 0);
    check("clean_ops",          op_addr.size() - op_base, 1);
    check("clean_refill_addr",  op_addr[op_base], 32'h240);
    check("clean_load",         g_rdata, 32'h0240_0000);

    // Third tag in set 2 evicts the dirty LRU line (tag 0).
    do_access(32'h440, 1'b0, '0, 3);
    check("dirty_done",        g_stalls < 200, 1);
    check("dirty_ops",         op_addr.size() - op_base, 2);
    check("dirty_wb_we",       op_we[op_base], 1);
    check("dirty_wb_addr",     op_addr[op_base], 32'h40);
    check("dirty_wb_data",     op_data[op_base], dirty_line);
    check("dirty_refill_we",   op_we[op_base + 1], 0);
    check("dirty_refill_addr", op_addr[op_base + 1], 32'h440);
    check("dirty_we_cycles",   we_cycles, 4);
    check("dirty_fill_tag",    fill_tag, 25'h100_0002);
    check("dirty_load",        g_rdata, 32'h0440_0000);

    // Zero-latency ack; refill brings back the line written back above.
    do_access(32'h44, 1'b0, '0, 0);
    check("lat0_stall_cycles", g_stalls, 3);
    check("lat0_refill_we",    op_we[op_base], 0);
    check("lat0_refill_addr",  op_addr[op_base], 32'h40);
    check("lat0_load",         g_rdata, 32'h1234_5678);

    // Reset in the middle of a refill, then a stray ack.
    ack_latency    = 20;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h840;
    repeat (5) @(negedge clk_i);
    check("abort_pre_mem_en", bus.mem_en_o, 1);
    check("abort_pre_addr",   bus.mem_addr_o, 32'h840);
    #2 rst_i = 1'b1;
    #1;
    check("abort_mem_en",  bus.mem_en_o, 0);
    check("abort_mem_we",  bus.mem_we_o, 0);
    check("abort_stall",   bus.cpu_stall_o, 0);
    check("abort_sram_en", bus.sram_en_o, 0);
    check("abort_sram_we", bus.sram_we_o, 0);
    check("abort_addr",    bus.mem_addr_o, 0);
    bus.cpu_req_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    wr_before = sram_writes;
    force_ack = 1'b1;
    @(posedge clk_i); #1 force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stray_sram_we", bus.sram_we_o, 0);
      check("stray_mem_en",  bus.mem_en_o, 0);
    end
    check("stray_no_write", sram_writes - wr_before, 0);
    @(posedge clk_i); #1;
    do_access(32'h44, 1'b0, '0, 0);
    check("post_abort_stall", g_stalls, 0);
    check("post_abort_load",  g_rdata, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
